io_port_responder: RTL and testbench
====================================

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1001_0040, giving the base of its 16-byte register window.
REQ-002 The block SHALL have parameter IN_WIDTH, default 8, giving the PortIn width.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port Address, input, 32 bits: processor data address (ALU result).
REQ-007 The block SHALL have port WriteData, input, 32 bits: processor store data.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: store strobe.
REQ-009 The block SHALL have port MemRead, input, 1 bit: load strobe.
REQ-010 The block SHALL have port ReadData, output, 32 bits: load response data.
REQ-011 The block SHALL have port Hit, output, 1 bit: Address decodes into the window.
REQ-012 The block SHALL have port PortIn, input, IN_WIDTH bits: asynchronous external input.
REQ-013 The block SHALL have port PortOut, output, 32 bits: registered external output.

Function
REQ-014 Hit SHALL be combinational: Hit = (Address[31:4] == BASE_ADDR[31:4]); Address[1:0] SHALL be ignored; offset = Address[3:2].
REQ-015 The register map SHALL be: offset 0 OUT (RW), 1 IN (RO), 2 STATUS (RO, clear-on-read), 3 TIMER (RW).
REQ-016 ReadData SHALL be combinational, same cycle as MemRead, and SHALL be 0 whenever MemRead=0 or Hit=0.
REQ-017 A write to OUT (MemWrite & Hit & offset 0) SHALL load WriteData at the clock edge; PortOut SHALL equal the OUT register.
REQ-018 Writes to IN or STATUS SHALL be ignored, with no side effect.
REQ-019 PortIn SHALL pass through a two-flop synchronizer (s1, s2); IN SHALL read s2 zero-extended to 32 bits.
REQ-020 A change register prev SHALL load s2 every cycle; when s2 != prev at an edge, STATUS.CHG (bit 0) SHALL set and STATUS.CNT (bits 15:8) SHALL increment, saturating at 255.
REQ-021 Latency: if PortIn changes before edge 1, IN SHALL show the new value after edge 2 and CHG SHALL be 1 after edge 3.
REQ-022 A read of STATUS (MemRead & Hit & offset 2) SHALL return the current value and clear CHG and CNT at that edge.
REQ-023 If a new change event coincides with a STATUS read, the next state SHALL be CHG=1, CNT=1 (the event is not lost).
REQ-024 STATUS bits 31:16 and 7:1 SHALL read 0.
REQ-025 TIMER SHALL increment by 1 every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-026 A TIMER write SHALL load WriteData and take priority over the increment that cycle; counting SHALL resume the next cycle.
REQ-027 If MemRead and MemWrite are both asserted, the write SHALL occur and ReadData SHALL show the pre-edge value.
REQ-028 A non-hit access SHALL change no state.

Reset
REQ-029 While reset=1 at an edge, OUT, s1, s2, prev, STATUS and TIMER SHALL all become 0, regardless of any concurrent access.
REQ-030 After reset, PortOut SHALL be 0, and with MemRead=0 ReadData SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending change detection, with no CHG set on the first post-reset edge unless s2 differs from prev=0.

Verification
REQ-032 The bench SHALL cover: store 32'hA5A5_0001 to BASE+0 -> PortOut=32'hA5A5_0001 after that edge, and a load of BASE+0 returns the same value.
REQ-033 The bench SHALL cover: PortIn 0x00->0x3C before edge 1 -> IN reads 0x3C after edge 2, STATUS reads 0x0000_0101 after edge 3, and reads 0 on the next load.
REQ-034 The bench SHALL cover: PortIn toggling for 300 changes -> STATUS reads 0x0000_FF01; a change coincident with the STATUS read leaves STATUS=0x0000_0101.
REQ-035 The bench SHALL cover: store 32'hFFFF_FFFE to BASE+12 -> TIMER reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on successive cycles.
REQ-036 The bench SHALL cover: load/store at BASE+16 -> Hit=0, ReadData=0, no register changes; store to BASE+4 -> IN unchanged.
REQ-037 The bench SHALL cover: reset=1 for one edge while MemWrite targets OUT -> PortOut=0, TIMER=0, STATUS=0.

Source files
------------

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O port for a simple load/store core.
// A 16-byte window at BASE_ADDR holds four word registers:
//   offset 0 OUT    (RW)  drives PortOut
//   offset 1 IN     (RO)  synchronized PortIn, zero-extended
//   offset 2 STATUS (RO)  {16'h0, CNT[7:0], 7'h0, CHG}, cleared by a read
//   offset 3 TIMER  (RW)  free-running cycle counter
// Bus semantics: MemRead and MemWrite are single-cycle strobes qualified by
// Hit. There is no back-pressure. Reads are combinational in the strobe cycle.
// Writes take effect at the clock edge that ends the strobe cycle. With both
// strobes set, the read returns the pre-edge value.
module io_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
  parameter int unsigned IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut
);

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_TIMER  = 2'd3;

  logic [1:0]          offset;
  logic                wr_out;
  logic                wr_timer;
  logic                rd_status;
  logic                change;
  logic [31:0]         out_q;
  logic [31:0]         timer_q;
  logic [IN_WIDTH-1:0] s1;
  logic [IN_WIDTH-1:0] s2;
  logic [IN_WIDTH-1:0] prev;
  logic                chg_q;
  logic [7:0]          cnt_q;
  logic [31:0]         in_word;
  logic [31:0]         status_word;
  logic                unused_addr_bits;

  // Byte lanes inside a word are not decoded.
  assign unused_addr_bits = ^Address[1:0];

  assign offset    = Address[3:2];
  assign Hit       = (Address[31:4] == BASE_ADDR[31:4]);
  assign wr_out    = MemWrite & Hit & (offset == OFF_OUT);
  assign wr_timer  = MemWrite & Hit & (offset == OFF_TIMER);
  assign rd_status = MemRead & Hit & (offset == OFF_STATUS);
  assign change    = (s2 != prev);
  assign PortOut   = out_q;

  // Zero-extend the synchronized input and assemble the status word.
  always_comb begin
    in_word                 = '0;
    in_word[IN_WIDTH-1:0]   = s2;
    status_word             = {16'h0000, cnt_q, 7'h00, chg_q};
  end

  // Combinational read mux; reads as zero unless a hitting load is active.
  always_comb begin
    ReadData = '0;
    if (MemRead && Hit) begin
      case (offset)
        OFF_OUT:    ReadData = out_q;
        OFF_IN:     ReadData = in_word;
        OFF_STATUS: ReadData = status_word;
        OFF_TIMER:  ReadData = timer_q;
        default:    ReadData = '0;
      endcase
    end
  end

  // OUT register, loaded only by a hitting store to offset 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (wr_out) begin
      out_q <= WriteData;
    end
  end

  // Two-flop synchronizer for PortIn plus the previous-sample register used
  // for change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // STATUS: a read clears it, but a change event at the same edge is kept as
  // the first event of the new interval. CNT saturates at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      chg_q <= 1'b0;
      cnt_q <= 8'd0;
    end else if (rd_status) begin
      chg_q <= change;
      cnt_q <= change ? 8'd1 : 8'd0;
    end else if (change) begin
      chg_q <= 1'b1;
      cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Free-running TIMER. A store overrides that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (wr_timer) begin
      timer_q <= WriteData;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: a vector table for single-cycle bus
// behaviour, then hand-written sequences for synchronizer latency, STATUS
// saturation and clear-on-read, TIMER wrap, and reset during activity.
module tb_io_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        hit;
  logic [7:0]  port_in;
  logic [31:0] port_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [31:0] exp_po;
  } vec_t;

  vec_t vecs[15];

  io_port_responder #(
    .BASE_ADDR (BASE),
    .IN_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (address),
    .WriteData (write_data),
    .MemWrite  (mem_write),
    .MemRead   (mem_read),
    .ReadData  (read_data),
    .Hit       (hit),
    .PortIn    (port_in),
    .PortOut   (port_out)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus cycle, then settle before sampling.
  task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata);
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"st_out",    1'b0, 1'b1, BASE,          32'hA5A5_0001, 32'h0,          1'b1, 32'h0};
    vecs[1]  = '{"ld_out",    1'b1, 1'b0, BASE,          32'h0,         32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
    vecs[2]  = '{"ld_out_b1", 1'b1, 1'b0, BASE + 32'd1,  32'h0,         32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
    vecs[3]  = '{"ld_in",     1'b1, 1'b0, BASE + 32'd4,  32'h0,         32'h0,          1'b1, 32'hA5A5_0001};
    vecs[4]  = '{"st_in",     1'b0, 1'b1, BASE + 32'd4,  32'hFFFF_FFFF, 32'h0,          1'b1, 32'hA5A5_0001};
    vecs[5]  = '{"ld_in2",    1'b1, 1'b0, BASE + 32'd4,  32'h0,         32'h0,          1'b1, 32'hA5A5_0001};
    vecs[6]  = '{"st_status", 1'b0, 1'b1, BASE + 32'd8,  32'hFFFF_FFFF, 32'h0,          1'b1, 32'hA5A5_0001};
    vecs[7]  = '{"ld_status", 1'b1, 1'b0, BASE + 32'd8,  32'h0,         32'h0,          1'b1, 32'hA5A5_0001};
    vecs[8]  = '{"rw_miss",   1'b1, 1'b1, BASE + 32'd16, 32'h1234_5678, 32'h0,          1'b0, 32'hA5A5_0001};
    vecs[9]  = '{"st_miss",   1'b0, 1'b1, BASE + 32'd16, 32'h5555_5555, 32'h0,          1'b0, 32'hA5A5_0001};
    vecs[10] = '{"ld_out3",   1'b1, 1'b0, BASE,          32'h0,         32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
    vecs[11] = '{"rw_out",    1'b1, 1'b1, BASE,          32'h0000_BEEF, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
    vecs[12] = '{"ld_out4",   1'b1, 1'b0, BASE,          32'h0,         32'h0000_BEEF, 1'b1, 32'h0000_BEEF};
    vecs[13] = '{"ld_below",  1'b1, 1'b0, BASE - 32'd16, 32'h0,         32'h0,          1'b0, 32'h0000_BEEF};
    vecs[14] = '{"idle_hit",  1'b0, 1'b0, BASE,          32'h0,         32'h0,          1'b1, 32'h0000_BEEF};

    reset      = 1'b1;
    port_in    = 8'h00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_portout", port_out, 32'h0);
    chk("rst_readdata", read_data, 32'h0);

    // Table: single-cycle bus behaviour with PortIn held at 0.
    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk({vecs[i].name, "_rd"},  read_data,        vecs[i].exp_rd);
      chk({vecs[i].name, "_hit"}, {31'b0, hit},     {31'b0, vecs[i].exp_hit});
      chk({vecs[i].name, "_po"},  port_out,         vecs[i].exp_po);
      tick();
    end

    // Synchronizer latency and clear-on-read.
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    port_in = 8'h3C;
    tick();                               // edge 1
    tick();                               // edge 2
    bus(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    chk("in_after_e2", read_data, 32'h0000_003C);
    tick();                               // edge 3
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("status_after_e3", read_data, 32'h0000_0101);
    tick();                               // read clears here
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("status_cleared", read_data, 32'h0);
    tick();

    // 300 input changes saturate CNT at 255.
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 300; i++) begin
      port_in = ~port_in;
      tick();
    end
    tick();
    tick();
    tick();
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("status_sat", read_data, 32'h0000_FF01);
    tick();

    // A change landing on the same edge as a STATUS read is kept.
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    port_in = ~port_in;
    tick();                               // edge 1
    tick();                               // edge 2
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("status_pre_coinc", read_data, 32'h0);
    tick();                               // edge 3: read and event coincide
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("status_coinc", read_data, 32'h0000_0101);
    tick();

    // TIMER load priority and wrap.
    bus(1'b0, 1'b1, BASE + 32'd12, 32'hFFFF_FFFE);
    tick();
    bus(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    chk("timer_load", read_data, 32'hFFFF_FFFE);
    tick();
    bus(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    chk("timer_max", read_data, 32'hFFFF_FFFF);
    tick();
    bus(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    chk("timer_wrap", read_data, 32'h0);
    tick();
    bus(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    chk("timer_resume", read_data, 32'h1);
    tick();

    // Reset with a store to OUT and a change event pending.
    bus(1'b0, 1'b1, BASE, 32'h1111_2222);
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst_out", port_out, 32'h1111_2222);
    port_in = 8'h5A;
    tick();
    tick();                               // s2=5A, prev differs: event pending
    reset = 1'b1;
    bus(1'b0, 1'b1, BASE, 32'hDEAD_0000);
    tick();                               // reset edge
    reset = 1'b0;
    bus(1'b1, 1'b0, BASE + 32'd12, 32'h0);
    chk("rst2_portout", port_out, 32'h0);
    chk("rst2_timer", read_data, 32'h0);
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("rst2_status", read_data, 32'h0);
    tick();                               // edge R+1
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("rst2_status_r1", read_data, 32'h0);
    tick();                               // edge R+2
    bus(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    chk("rst2_in_resync", read_data, 32'h0000_005A);
    tick();                               // edge R+3
    bus(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    chk("rst2_status_r3", read_data, 32'h0000_0101);
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
